// File: rtl/single_adder_pkg.sv
// Purpose: shared constants for the single_adder block (default width, flag bit positions).
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake).
package single_adder_pkg;

  // Default operand/result width of the adder.
  localparam int DEFAULT_WIDTH = 32;

  // Bit positions inside the 4-bit {N, Z, C, V} flags word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : single_adder_pkg

// File: rtl/single_adder_full_adder.sv
// Purpose: one-bit full adder cell used to build the ripple-carry chain.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports:
//   a, b  - operand bits
//   cin   - carry in from the next-lower bit
//   s     - sum bit
//   cout  - carry out to the next-higher bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  // Carry is generated by a&b or propagated when exactly one operand bit is set.
  assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/single_adder.sv
// Purpose: N-bit ripple-carry adder with combinational sum/carry/overflow and registered sum + {N,Z,C,V} flags.
// Latency: Y/C/V combinational (0 cycles); Y_q/flags_q one cycle after the operands.
// Backpressure: none; a new operand pair is accepted and registered on every clock edge.
//
// Ports:
//   clk     - clock, registers update on its rising edge
//   rst     - synchronous active-high reset of Y_q/flags_q only
//   A, B    - operands (sign-agnostic)
//   Y       - (A + B) mod 2^N, combinational
//   C       - carry out of bit N-1, combinational
//   V       - signed overflow, combinational
//   Y_q     - registered Y
//   flags_q - registered {N, Z, C, V} of the registered sum
module single_adder
  import single_adder_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Y,
  output logic         C,
  output logic         V,
  output logic [N-1:0] Y_q,
  output logic [3:0]   flags_q
);

  // carry[i] feeds bit i; carry[N] is the adder's carry-out. Carry-in is tied low.
  logic [N:0] carry;
  logic [3:0] flags_d;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_ripple
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (Y[i]),
      .cout (carry[i+1])
    );
  end

  assign C = carry[N];
  // Overflow: operands share a sign but the result's sign differs from it.
  assign V = (A[N-1] == B[N-1]) && (Y[N-1] != A[N-1]);

  always_comb begin
    flags_d         = 4'b0000;
    flags_d[FLAG_N] = Y[N-1];
    flags_d[FLAG_Z] = (Y == '0);
    flags_d[FLAG_C] = C;
    flags_d[FLAG_V] = V;
  end

  // Reset only clears the registers; the combinational outputs keep tracking A/B.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_q     <= '0;
      flags_q <= 4'b0000;
    end else begin
      Y_q     <= Y;
      flags_q <= flags_d;
    end
  end

endmodule : single_adder

// File: tb/tb_single_adder.sv
// Purpose: self-checking bench for single_adder at N=32 and N=8 (directed vectors plus random vs. arithmetic model).
// Latency: checks combinational outputs 1ns after inputs change, registered outputs 1ns after the rising edge.
// Backpressure: n/a.
module tb_single_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] a32, b32, y32, y32_q;
  logic        c32, v32;
  logic [3:0]  f32_q;

  logic [7:0]  a8, b8, y8, y8_q;
  logic        c8, v8;
  logic [3:0]  f8_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  single_adder #(.N(32)) u_dut32 (
    .clk     (clk),
    .rst     (rst),
    .A       (a32),
    .B       (b32),
    .Y       (y32),
    .C       (c32),
    .V       (v32),
    .Y_q     (y32_q),
    .flags_q (f32_q)
  );

  single_adder #(.N(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .A       (a8),
    .B       (b8),
    .Y       (y8),
    .C       (c8),
    .V       (v8),
    .Y_q     (y8_q),
    .flags_q (f8_q)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model from plain integer arithmetic: unsigned sum for Y/C,
  // signed-range test for V.
  task automatic ref_add(input int w, input longint a, input longint b,
                         output longint y, output bit c, output bit v,
                         output logic [3:0] f);
    longint modv, half, sum, sa, sb, ssum;
    modv = longint'(1) << w;
    half = modv / 2;
    sum  = a + b;
    y    = sum % modv;
    c    = (sum >= modv);
    sa   = (a >= half) ? a - modv : a;
    sb   = (b >= half) ? b - modv : b;
    ssum = sa + sb;
    v    = (ssum >= half) || (ssum < -half);
    f    = {(y >= half), (y == 0), c, v};
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        c;
    logic        v;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[4];

  initial begin
    longint    ey;
    bit        ec, ev;
    logic [3:0] ef;
    longint    ey8;
    bit        ec8, ev8;
    logic [3:0] ef8;
    bit        r;

    vecs[0] = '{32'hE59F1020, 32'h00000004, 32'hE59F1024, 1'b0, 1'b0, 4'b1000};
    vecs[1] = '{32'h509F1018, 32'h8AFFFFF8, 32'hDB9F1010, 1'b0, 1'b0, 4'b1000};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 4'b0110};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 4'b1001};

    // Reset state.
    rst = 1'b1;
    a32 = 32'h0; b32 = 32'h0; a8 = 8'h0; b8 = 8'h0;
    @(posedge clk); #1;
    check("rst_yq32", 64'(y32_q), 64'h0);
    check("rst_f32",  64'(f32_q), 64'h0);
    check("rst_yq8",  64'(y8_q),  64'h0);
    check("rst_f8",   64'(f8_q),  64'h0);

    // Directed vectors with known answers.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a32 = vecs[i].a; b32 = vecs[i].b;
      #1;
      check($sformatf("dir%0d_y", i), 64'(y32), 64'(vecs[i].y));
      check($sformatf("dir%0d_c", i), 64'(c32), 64'(vecs[i].c));
      check($sformatf("dir%0d_v", i), 64'(v32), 64'(vecs[i].v));
      @(posedge clk); #1;
      check($sformatf("dir%0d_yq", i), 64'(y32_q), 64'(vecs[i].y));
      check($sformatf("dir%0d_fq", i), 64'(f32_q), 64'(vecs[i].f));
      @(negedge clk);
    end

    // 8-bit wrap: 0xFF + 0x01.
    a8 = 8'hFF; b8 = 8'h01;
    #1;
    check("w8_y", 64'(y8), 64'h00);
    check("w8_c", 64'(c8), 64'h1);
    check("w8_v", 64'(v8), 64'h0);
    @(posedge clk); #1;
    check("w8_fq", 64'(f8_q), 64'b0110);

    // Reset mid-stream: combinational path keeps tracking, registers clear.
    @(negedge clk);
    rst = 1'b1;
    a32 = 32'h12345678; b32 = 32'h12345678;
    #1;
    check("mid_y_during_rst", 64'(y32), 64'h2468ACF0);
    @(posedge clk); #1;
    check("mid_yq_rst",  64'(y32_q), 64'h0);
    check("mid_fq_rst",  64'(f32_q), 64'h0);
    check("mid_y_after_edge", 64'(y32), 64'h2468ACF0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_yq_rel", 64'(y32_q), 64'h2468ACF0);
    check("mid_fq_rel", 64'(f32_q), 64'h0);

    // Random operands with occasional reset pulses and forced zero sums.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a32 = $urandom;
      b32 = ($urandom_range(0, 9) == 0) ? (32'h0 - a32) : 32'($urandom);
      a8  = 8'($urandom);
      b8  = ($urandom_range(0, 9) == 0) ? (8'h0 - a8) : 8'($urandom);
      r   = ($urandom_range(0, 7) == 0);
      rst = r;
      ref_add(32, longint'(a32), longint'(b32), ey, ec, ev, ef);
      ref_add(8,  longint'(a8),  longint'(b8),  ey8, ec8, ev8, ef8);
      #1;
      check("rnd_y32", 64'(y32), 64'(ey));
      check("rnd_c32", 64'(c32), 64'(ec));
      check("rnd_v32", 64'(v32), 64'(ev));
      check("rnd_y8",  64'(y8),  64'(ey8));
      check("rnd_c8",  64'(c8),  64'(ec8));
      check("rnd_v8",  64'(v8),  64'(ev8));
      @(posedge clk); #1;
      check("rnd_yq32", 64'(y32_q), r ? 64'h0 : 64'(ey));
      check("rnd_fq32", 64'(f32_q), r ? 64'h0 : 64'(ef));
      check("rnd_yq8",  64'(y8_q),  r ? 64'h0 : 64'(ey8));
      check("rnd_fq8",  64'(f8_q),  r ? 64'h0 : 64'(ef8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_single_adder
